// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parametrised UART receiver
// Purpose: receiver state encoding, parity-mode constants and the bit-timing
//   helper shared by uart_rx_param and its sub-modules.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clocks from the detected start edge to the start-bit centre.
  function automatic int half_period(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high serial line
// Purpose: bring the asynchronous rx pin into the clk domain. Both flops reset
//   to 1 so a reset never looks like a start edge.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   async_i - asynchronous input (idles high)
//   sync_o  - synchronised output, 2 clocks of latency
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity and framing checks
// Purpose: receive LSB-first frames of DATA_BITS data bits, optional parity and
//   STOP_BITS stop bits; one rx_done pulse per frame.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
//   around each bit centre (decision one clock later; CLKS_PER_BIT >= 8).
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial line, idles high
//   rx_done    - one-cycle pulse when a frame completes
//   rx_byte    - received data, held until the next rx_done
//   parity_err - parity mismatch of the last frame
//   frame_err  - a stop bit of the last frame was sampled low
//   busy       - receiver is not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MIN_CLKS = 8;
  localparam int SKEW     = 1;
`else
  localparam int MIN_CLKS = 4;
  localparam int SKEW     = 0;
`endif

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;

  // With majority sampling every decision moves to centre+1; since the data
  // counter restarts at that point, later bits shift by the same one clock.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(half_period(CLKS_PER_BIT) + SKEW);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS) begin : g_bad_clks
    $error("uart_rx_param: CLKS_PER_BIT too small");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_s;
  logic bit_val;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous samples plus the current one form the 3-sample window.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q;
  logic                 frm_acc_q;
  logic                 rx_done_q;
  logic [DATA_BITS-1:0] rx_byte_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  logic bit_tick;
  logic par_err_d;
  logic frm_err_d;

  assign bit_tick  = (cnt_q == BIT_LAST);
  // Data plus parity must have even weight (even mode) or odd weight (odd mode).
  assign par_err_d = ((^shift_q) ^ bit_val) != (PARITY_MODE == PARITY_ODD);
  assign frm_err_d = frm_acc_q | ~bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      frm_acc_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_byte_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          idx_q     <= '0;
          par_acc_q <= 1'b0;
          frm_acc_q <= 1'b0;
          if (!rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == START_DEC) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            // A start bit that is high again at its centre was a glitch.
            state_q <= bit_val ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
            if (idx_q == DATA_LAST) begin
              idx_q   <= '0;
              state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_acc_q <= par_err_d;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            frm_acc_q <= frm_err_d;
            if (idx_q == STOP_LAST) begin
              idx_q        <= '0;
              rx_done_q    <= 1'b1;
              rx_byte_q    <= shift_q;
              parity_err_q <= par_acc_q;
              frame_err_q  <= frm_err_d;
              // A low stop bit may be a line break; wait for the line to
              // recover so it is not decoded as a stream of zero frames.
              state_q      <= frm_err_d ? WAIT_IDLE : IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_done    = rx_done_q;
  assign rx_byte    = rx_byte_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param
module tb_uart_rx_param;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_SKEW = 1;
`else
  localparam int LAT_SKEW = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx;

  always #5 clk = ~clk;

  logic       done_n1, perr_n1, ferr_n1, busy_n1;
  logic [7:0] byte_n1;
  logic       done_e1, perr_e1, ferr_e1, busy_e1;
  logic [7:0] byte_e1;
  logic       done_n2, perr_n2, ferr_n2, busy_n2;
  logic [7:0] byte_n2;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst(rst), .rx(rx), .rx_done(done_n1), .rx_byte(byte_n1),
    .parity_err(perr_n1), .frame_err(ferr_n1), .busy(busy_n1));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .rst(rst), .rx(rx), .rx_done(done_e1), .rx_byte(byte_e1),
    .parity_err(perr_e1), .frame_err(ferr_e1), .busy(busy_e1));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_8n2 (
    .clk(clk), .rst(rst), .rx(rx), .rx_done(done_n2), .rx_byte(byte_n2),
    .parity_err(perr_n2), .frame_err(ferr_n2), .busy(busy_n2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; logic perr; logic ferr; } ev_t;
  typedef struct { logic [7:0] data; logic perr; logic ferr; } exp_t;

  ev_t  ev_n1[$];
  ev_t  ev_e1[$];
  ev_t  ev_n2[$];
  exp_t exp_q[$];
  logic done_prev_n1 = 1'b0;
  logic busy_after_n1 = 1'b1;

  // Completed frames of each receiver, stamped with the clock count.
  always @(negedge clk) begin
    ev_t e;
    if (done_n1 === 1'b1) begin
      e.cyc = cyc; e.data = byte_n1; e.perr = perr_n1; e.ferr = ferr_n1;
      ev_n1.push_back(e);
    end
    if (done_e1 === 1'b1) begin
      e.cyc = cyc; e.data = byte_e1; e.perr = perr_e1; e.ferr = ferr_e1;
      ev_e1.push_back(e);
    end
    if (done_n2 === 1'b1) begin
      e.cyc = cyc; e.data = byte_n2; e.perr = perr_n2; e.ferr = ferr_n2;
      ev_n2.push_back(e);
    end
    if (done_prev_n1 === 1'b1) busy_after_n1 = busy_n1;
    done_prev_n1 = done_n1;
  end

  bit tx_q[$];
  int tx_start_cyc;

  task automatic build_frame(input logic [7:0] d, input bit has_par, input bit pbit,
                             input int nstop, input bit stop_low);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
    if (has_par) tx_q.push_back(pbit);
    tx_q.push_back(~stop_low);
    if (nstop == 2) tx_q.push_back(1'b1);
  endtask

  task automatic send_bits();
    tx_start_cyc = cyc;
    while (tx_q.size() > 0) begin
      rx = tx_q.pop_front();
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic settle();
    idle_bits(30);
    ev_n1.delete(); ev_e1.delete(); ev_n2.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [4:0] got [3];
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    got[0] = {done_n1, |byte_n1, perr_n1, ferr_n1, busy_n1};
    got[1] = {done_e1, |byte_e1, perr_e1, ferr_e1, busy_e1};
    got[2] = {done_n2, |byte_n2, perr_n2, ferr_n2, busy_n2};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got {done,byte!=0,perr,ferr,busy}=%b want 00000", i, got[i]);
      end
    end
    checks++;
    if (byte_n1 !== 8'h00) begin
      errors++; $display("FAIL reset_byte got %h want 00", byte_n1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int start;
    settle();
    build_frame(8'hA5, 1'b0, 1'b0, 1, 1'b0);
    send_bits();
    start = tx_start_cyc;
    idle_bits(4);
    checks++;
    if (ev_n1.size() !== 1) begin
      errors++; $display("FAIL basic_count got %0d want 1", ev_n1.size());
    end
    if (ev_n1.size() > 0) begin
      lat = ev_n1[0].cyc - start;
      checks++;
      if (lat < 151 + LAT_SKEW || lat > 155 + LAT_SKEW) begin
        errors++; $display("FAIL basic_latency got %0d want %0d+-2", lat, 153 + LAT_SKEW);
      end
      checks++;
      if (ev_n1[0].data !== 8'hA5) begin
        errors++; $display("FAIL basic_data got %h want a5", ev_n1[0].data);
      end
      checks++;
      if (ev_n1[0].perr !== 1'b0 || ev_n1[0].ferr !== 1'b0) begin
        errors++; $display("FAIL basic_flags got perr=%b ferr=%b want 0 0", ev_n1[0].perr, ev_n1[0].ferr);
      end
      checks++;
      if (busy_after_n1 !== 1'b0) begin
        errors++; $display("FAIL basic_busy_after got %b want 0", busy_after_n1);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    settle();
    for (int i = 0; i < 48; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy_n1 === 1'b1) busy_cnt++;
    end
    idle_bits(12);
    checks++;
    if (busy_cnt < 1 || busy_cnt > 10) begin
      errors++; $display("FAIL glitch_busy got %0d clocks want 1..10", busy_cnt);
    end
    checks++;
    if (ev_n1.size() !== 0) begin
      errors++; $display("FAIL glitch_no_done got %0d want 0", ev_n1.size());
    end
    checks++;
    if (busy_n1 !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_end got %b want 0", busy_n1);
    end
  endtask

  task automatic test_random();
    exp_t x;
    logic [7:0] d;
    bit sl;
    settle();
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      sl = ($urandom_range(0, 3) == 0);
      build_frame(d, 1'b0, 1'b0, 1, sl);
      x.data = d; x.perr = 1'b0; x.ferr = sl;
      exp_q.push_back(x);
      send_bits();
      idle_bits(sl ? 2 : int'($urandom_range(0, 2)));
    end
    idle_bits(4);
    checks++;
    if (ev_n1.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", ev_n1.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_n1.size(); i++) begin
      checks++;
      if (ev_n1[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL rand_data[%0d] got %h want %h", i, ev_n1[i].data, exp_q[i].data);
      end
      checks++;
      if (ev_n1[i].perr !== 1'b0 || ev_n1[i].ferr !== exp_q[i].ferr) begin
        errors++;
        $display("FAIL rand_flags[%0d] got perr=%b ferr=%b want 0 %b", i, ev_n1[i].perr, ev_n1[i].ferr, exp_q[i].ferr);
      end
    end
  endtask

  task automatic test_parity();
    exp_t x;
    logic [7:0] d;
    bit pb;
    settle();
    for (int k = 0; k < 6; k++) begin
      if (k < 2) begin
        d  = 8'h03;
        pb = (k == 0);
      end else begin
        d  = 8'($urandom);
        pb = 1'($urandom_range(0, 1));
      end
      build_frame(d, 1'b1, pb, 1, 1'b0);
      // Even parity: data plus parity bit must contain an even number of ones.
      x.data = d; x.perr = ((($countones(d) + int'(pb)) % 2) != 0); x.ferr = 1'b0;
      exp_q.push_back(x);
      send_bits();
      idle_bits(1);
    end
    idle_bits(4);
    checks++;
    if (ev_e1.size() !== exp_q.size()) begin
      errors++; $display("FAIL parity_count got %0d want %0d", ev_e1.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_e1.size(); i++) begin
      checks++;
      if (ev_e1[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL parity_data[%0d] got %h want %h", i, ev_e1[i].data, exp_q[i].data);
      end
      checks++;
      if (ev_e1[i].perr !== exp_q[i].perr || ev_e1[i].ferr !== 1'b0) begin
        errors++;
        $display("FAIL parity_flags[%0d] got perr=%b ferr=%b want %b 0", i, ev_e1[i].perr, ev_e1[i].ferr, exp_q[i].perr);
      end
    end
  endtask

  task automatic test_break();
    int n_low;
    settle();
    rx = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    n_low = ev_n1.size();
    idle_bits(3);
    checks++;
    if (n_low !== 1) begin
      errors++; $display("FAIL break_count got %0d want 1", n_low);
    end
    build_frame(8'h7E, 1'b0, 1'b0, 1, 1'b0);
    send_bits();
    idle_bits(4);
    checks++;
    if (ev_n1.size() !== 2) begin
      errors++; $display("FAIL break_total got %0d want 2", ev_n1.size());
    end
    if (ev_n1.size() > 0) begin
      checks++;
      if (ev_n1[0].data !== 8'h00 || ev_n1[0].ferr !== 1'b1 || ev_n1[0].perr !== 1'b0) begin
        errors++;
        $display("FAIL break_frame got data=%h ferr=%b perr=%b want 00 1 0", ev_n1[0].data, ev_n1[0].ferr, ev_n1[0].perr);
      end
    end
    if (ev_n1.size() > 1) begin
      checks++;
      if (ev_n1[1].data !== 8'h7E || ev_n1[1].ferr !== 1'b0) begin
        errors++; $display("FAIL break_recover got data=%h ferr=%b want 7e 0", ev_n1[1].data, ev_n1[1].ferr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    settle();
    build_frame(8'h55, 1'b0, 1'b0, 2, 1'b0);
    build_frame(8'hAA, 1'b0, 1'b0, 2, 1'b0);
    send_bits();
    idle_bits(4);
    checks++;
    if (ev_n2.size() !== 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", ev_n2.size());
    end
    if (ev_n2.size() == 2) begin
      // 11 bit times per frame: start, 8 data, 2 stop.
      gap = ev_n2[1].cyc - ev_n2[0].cyc;
      checks++;
      if (gap < 11 * CPB - 2 || gap > 11 * CPB + 2) begin
        errors++; $display("FAIL b2b_spacing got %0d want %0d+-2", gap, 11 * CPB);
      end
      checks++;
      if (ev_n2[0].data !== 8'h55 || ev_n2[1].data !== 8'hAA) begin
        errors++; $display("FAIL b2b_data got %h %h want 55 aa", ev_n2[0].data, ev_n2[1].data);
      end
      checks++;
      if (ev_n2[0].ferr !== 1'b0 || ev_n2[1].ferr !== 1'b0) begin
        errors++; $display("FAIL b2b_ferr got %b %b want 0 0", ev_n2[0].ferr, ev_n2[1].ferr);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] got;
    settle();
    build_frame(8'h5A, 1'b0, 1'b0, 1, 1'b0);
    // Start bit and data bits 0..3, then halfway into data bit 4.
    for (int i = 0; i < 5; i++) begin
      rx = tx_q.pop_front();
      repeat (CPB) @(negedge clk);
    end
    rx = tx_q.pop_front();
    repeat (CPB / 2) @(negedge clk);
    tx_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    got = {done_n1, |byte_n1, perr_n1, ferr_n1, busy_n1};
    checks++;
    if (got !== 5'b0) begin
      errors++; $display("FAIL midreset_outputs got {done,byte!=0,perr,ferr,busy}=%b want 00000", got);
    end
    idle_bits(20);
    checks++;
    if (ev_n1.size() !== 0) begin
      errors++; $display("FAIL midreset_no_done got %0d want 0", ev_n1.size());
    end
    build_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
    send_bits();
    idle_bits(4);
    checks++;
    if (ev_n1.size() !== 1) begin
      errors++; $display("FAIL midreset_next_count got %0d want 1", ev_n1.size());
    end
    if (ev_n1.size() > 0) begin
      checks++;
      if (ev_n1[0].data !== 8'h3C || ev_n1[0].ferr !== 1'b0 || ev_n1[0].perr !== 1'b0) begin
        errors++;
        $display("FAIL midreset_next got data=%h ferr=%b perr=%b want 3c 0 0", ev_n1[0].data, ev_n1[0].ferr, ev_n1[0].perr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_random();
    test_parity();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
